pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage MIPS pipeline. It drives hold and bubble
//  controls for the PC, the IF/ID register and the ID/EX register (its d_h flush input).
//  Detects load-use hazards, squashes wrong-path instructions on a taken branch or jump,
//  and freezes the pipe while a multi-cycle data-memory access is outstanding.
// PARAMETERS
//  FLUSH_CYCLES  1   IF/ID bubble cycles after a redirect (1..7)
//  MEM_TIMEOUT   64  max MEM_WAIT cycles before an abort (>=2)
//  CNT_W         16  width of the stall performance counter
// PORTS
//  clock         in   1      single clock, rising edge
//  resetn        in   1      synchronous, active-low reset
//  id_rs         in   5      rs field of the instruction in ID
//  id_rt         in   5      rt field of the instruction in ID
//  id_uses_rt    in   1      ID instruction reads rt (R-type, sw, beq)
//  ex_re         in   1      re_in_out of ID/EX (load in EX)
//  ex_regwrite   in   1      RegWrite_out of ID/EX
//  ex_write_reg  in   5      write_reg_out of ID/EX
//  br_taken      in   1      branch resolved taken this cycle
//  jump          in   1      Jump_out of ID/EX
//  mem_req       in   1      MEM stage has an access in flight
//  mem_ready     in   1      data memory completes the access this cycle
//  stall_pc      out  1      hold the PC
//  stall_id      out  1      hold IF/ID
//  stall_ex      out  1      hold ID/EX and EX/MEM
//  flush_id      out  1      load a bubble into IF/ID
//  flush_ex      out  1      drive ID/EX d_h (bubble)
//  mem_timeout   out  1      one-cycle pulse when the memory wait aborts
//  state_o       out  2      current FSM state (debug)
//  stall_cnt     out  CNT_W  saturating count of cycles with stall_pc=1
// BEHAVIOUR
//  - States: RUN=0, MEM_WAIT=1, FLUSH=2. Outputs decode as a Mealy function of state and
//    inputs; the same cycle that a condition is seen acts on it.
//  - Reset (resetn=0 at a clock edge): state<=RUN, flush counter<=0, wait counter<=0,
//    stall_cnt<=0. While resetn=0: flush_id=flush_ex=1, all stalls=0, mem_timeout=0.
//  - Load-use hazard lu = ex_re & ex_regwrite & (ex_write_reg!=0) &
//    (ex_write_reg==id_rs | (id_uses_rt & ex_write_reg==id_rt)). $0 never hazards.
//  - Redirect rd = br_taken | jump.
//  - Priority in RUN: memory wait > redirect > load-use.
//    - mem_req & !mem_ready: stall_pc=stall_id=stall_ex=1, no flushes; next=MEM_WAIT, wcnt<=1.
//    - else rd: flush_id=flush_ex=1, no stalls. If FLUSH_CYCLES>1, next=FLUSH and
//      fcnt<=FLUSH_CYCLES-1. A redirect squashes any coincident load-use.
//    - else lu: stall_pc=stall_id=1, flush_ex=1 for exactly one cycle; stay in RUN. Next
//      cycle lu deasserts naturally because the bubble clears ex_re.
//    - else all outputs 0.
//  - MEM_WAIT: stall_pc=stall_id=stall_ex=1 every cycle; wcnt increments.
//    - mem_ready=1: stalls still asserted this cycle; next=RUN.
//    - wcnt==MEM_TIMEOUT-1 & !mem_ready: mem_timeout=1 and flush_ex=1 this cycle; next=RUN.
//    - br_taken/jump are ignored (EX is frozen).
//  - FLUSH: flush_id=1, fcnt decrements; fcnt==1 -> next=RUN.
//    - mem_req & !mem_ready preempts: next=MEM_WAIT, remaining flushes are dropped.
//  - stall_cnt increments on every cycle with stall_pc=1 and saturates at all-ones.
//  - Counter widths are $clog2 of their parameters plus 1; no wrap-around is permitted.
// STRUCTURE
//  - Shared package pipe_ctrl_pkg: state encodings RUN/MEM_WAIT/FLUSH, REG_ZERO=5'd0.
//  - One sub-module: hazard_detect (combinational lu compare), reused by the forwarding unit.
//  - FSM and counters live in this module.
// TESTING
//  1 lw $3 in EX (ex_re=1, ex_write_reg=3), ID add with rs=3 -> 1 cycle of stall_pc,
//    stall_id and flush_ex; the next cycle is clean.
//  2 ex_write_reg=0 with ex_re=1 and id_rs=0 -> no stall.
//    id_rt match with id_uses_rt=0 -> no stall.
//  3 br_taken and lu in the same cycle -> flush_id=flush_ex=1, stall_pc=0.
//    With FLUSH_CYCLES=3, flush_id holds for 3 cycles total.
//  4 mem_req=1 and mem_ready rising after 5 cycles -> 6 stall cycles, then RUN.
//    stall_cnt=6.
//  5 mem_req held with mem_ready=0 and MEM_TIMEOUT=8 -> mem_timeout pulses in the 8th
//    wait cycle with flush_ex=1, then RUN.
//  6 resetn low mid-MEM_WAIT -> next state RUN, stall_cnt=0, and flushes asserted while
//    resetn is low.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state encodings and register constants for pipeline control
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } state_t;
   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use compare between the load in EX and the instruction in ID
//   rs_i, rt_i       source fields of the ID instruction
//   uses_rt_i        ID instruction actually reads rt
//   ex_re_i          load in EX
//   ex_regwrite_i    EX instruction writes the register file
//   ex_write_reg_i   destination of the EX instruction
//   lu_o             load-use hazard present
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] rs_i,
   input  logic [4:0] rt_i,
   input  logic       uses_rt_i,
   input  logic       ex_re_i,
   input  logic       ex_regwrite_i,
   input  logic [4:0] ex_write_reg_i,
   output logic       lu_o
);
   // $0 is hardwired, so a load targeting it never creates a dependency
   assign lu_o = ex_re_i & ex_regwrite_i & (ex_write_reg_i != REG_ZERO) &
                 ((ex_write_reg_i == rs_i) | (uses_rt_i & (ex_write_reg_i == rt_i)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencing for the 5-stage pipeline (load-use, redirect, memory wait)
//   clock, resetn                  rising-edge clock, synchronous active-low reset
//   id_rs, id_rt, id_uses_rt       ID instruction operands
//   ex_re, ex_regwrite, ex_write_reg  EX instruction (load / destination)
//   br_taken, jump                 redirect resolved this cycle
//   mem_req, mem_ready             data-memory handshake
//   stall_pc, stall_id, stall_ex   hold controls
//   flush_id, flush_ex             bubble controls for IF/ID and ID/EX
//   mem_timeout                    pulse when a memory wait is aborted
//   state_o, stall_cnt             debug state and saturating PC-stall counter
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int MEM_TIMEOUT  = 64,
   parameter int CNT_W        = 16
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_re,
   input  logic             ex_regwrite,
   input  logic [4:0]       ex_write_reg,
   input  logic             br_taken,
   input  logic             jump,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             stall_pc,
   output logic             stall_id,
   output logic             stall_ex,
   output logic             flush_id,
   output logic             flush_ex,
   output logic             mem_timeout,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt
);
   localparam int FW = $clog2(FLUSH_CYCLES) + 1;
   localparam int WW = $clog2(MEM_TIMEOUT) + 1;
   state_t           state_q, state_d;
   logic [FW-1:0]    fcnt_q, fcnt_d;
   logic [WW-1:0]    wcnt_q, wcnt_d;
   logic [CNT_W-1:0] cnt_q;
   logic             lu, rd, mem_wait;
   hazard_detect u_hd (
      .rs_i           (id_rs),
      .rt_i           (id_rt),
      .uses_rt_i      (id_uses_rt),
      .ex_re_i        (ex_re),
      .ex_regwrite_i  (ex_regwrite),
      .ex_write_reg_i (ex_write_reg),
      .lu_o           (lu)
   );
   assign rd        = br_taken | jump;
   assign mem_wait  = mem_req & ~mem_ready;
   assign state_o   = state_q;
   assign stall_cnt = cnt_q;
   always_comb begin
      state_d     = state_q;
      fcnt_d      = fcnt_q;
      wcnt_d      = wcnt_q;
      stall_pc    = 1'b0;
      stall_id    = 1'b0;
      stall_ex    = 1'b0;
      flush_id    = 1'b0;
      flush_ex    = 1'b0;
      mem_timeout = 1'b0;
      if (!resetn) begin
         flush_id = 1'b1;
         flush_ex = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (mem_wait) begin
                  {stall_pc, stall_id, stall_ex} = 3'b111;
                  state_d = MEM_WAIT;
                  wcnt_d  = WW'(1);
               end else if (rd) begin
                  {flush_id, flush_ex} = 2'b11;
                  if (FLUSH_CYCLES > 1) begin
                     state_d = FLUSH;
                     fcnt_d  = FW'(FLUSH_CYCLES - 1);
                  end
               end else if (lu) begin
                  {stall_pc, stall_id, flush_ex} = 3'b111;
               end
            end
            MEM_WAIT: begin
               {stall_pc, stall_id, stall_ex} = 3'b111;
               wcnt_d = wcnt_q + 1'b1;
               if (mem_ready) begin
                  state_d = RUN;
               end else if (wcnt_q == WW'(MEM_TIMEOUT - 1)) begin
                  mem_timeout = 1'b1;
                  flush_ex    = 1'b1;
                  state_d     = RUN;
               end
            end
            FLUSH: begin
               // a new memory wait takes priority and drops the remaining bubbles
               if (mem_wait) begin
                  {stall_pc, stall_id, stall_ex} = 3'b111;
                  state_d = MEM_WAIT;
                  wcnt_d  = WW'(1);
               end else begin
                  flush_id = 1'b1;
                  fcnt_d   = fcnt_q - 1'b1;
                  state_d  = (fcnt_q == FW'(1)) ? RUN : FLUSH;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= RUN;
         fcnt_q  <= '0;
         wcnt_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         wcnt_q  <= wcnt_d;
         if (stall_pc && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed + random stimulus with a queue scoreboard against a rule-level model
module tb_pipe_hazard_ctrl;
   localparam int FC   = 3;
   localparam int MT   = 8;
   localparam int CW   = 5;
   localparam int CMAX = (1 << CW) - 1;
   typedef logic [12:0] exp_t;
   logic          clk;
   logic          resetn;
   logic [4:0]    id_rs, id_rt, ex_write_reg;
   logic          id_uses_rt, ex_re, ex_regwrite, br_taken, jump, mem_req, mem_ready;
   logic          stall_pc, stall_id, stall_ex, flush_id, flush_ex, mem_timeout;
   logic [1:0]    state_o;
   logic [CW-1:0] stall_cnt;
   exp_t          q[$];
   int            n_pass = 0;
   int            n_total = 0;
   int            n_cyc = 0;
   int            m_wait = 0;
   int            m_flush = 0;
   int            m_cnt = 0;

   pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clock        (clk),
      .resetn       (resetn),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rt   (id_uses_rt),
      .ex_re        (ex_re),
      .ex_regwrite  (ex_regwrite),
      .ex_write_reg (ex_write_reg),
      .br_taken     (br_taken),
      .jump         (jump),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .stall_pc     (stall_pc),
      .stall_id     (stall_id),
      .stall_ex     (stall_ex),
      .flush_id     (flush_id),
      .flush_ex     (flush_ex),
      .mem_timeout  (mem_timeout),
      .state_o      (state_o),
      .stall_cnt    (stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // model: m_wait = stall cycles already spent on the current access (0 = none),
   // m_flush = bubble cycles still owed, m_cnt = total PC-stall cycles (capped)
   task automatic step();
      logic       lu, rd, mw, sp, si, se, fi, fe, to;
      logic [1:0] st;
      logic [4:0] c;
      lu = ex_re && ex_regwrite && ex_write_reg != 5'd0 &&
           (ex_write_reg == id_rs || (id_uses_rt && ex_write_reg == id_rt));
      rd = br_taken || jump;
      mw = mem_req && !mem_ready;
      {sp, si, se, fi, fe, to} = 6'b0;
      st = (m_wait > 0) ? 2'd1 : (m_flush > 0) ? 2'd2 : 2'd0;
      c  = 5'(m_cnt);
      if (!resetn) begin
         fi = 1'b1; fe = 1'b1;
         m_wait = 0; m_flush = 0; m_cnt = 0;
      end else begin
         if (m_wait > 0) begin
            {sp, si, se} = 3'b111;
            if (mem_ready) m_wait = 0;
            else if (m_wait + 1 == MT) begin
               to = 1'b1; fe = 1'b1; m_wait = 0;
            end else m_wait++;
         end else if (m_flush > 0) begin
            if (mw) begin
               {sp, si, se} = 3'b111; m_wait = 1; m_flush = 0;
            end else begin
               fi = 1'b1; m_flush--;
            end
         end else if (mw) begin
            {sp, si, se} = 3'b111; m_wait = 1;
         end else if (rd) begin
            fi = 1'b1; fe = 1'b1; m_flush = FC - 1;
         end else if (lu) begin
            sp = 1'b1; si = 1'b1; fe = 1'b1;
         end
         if (sp && m_cnt < CMAX) m_cnt++;
      end
      q.push_back({sp, si, se, fi, fe, to, st, c});
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      {id_rs, id_rt, ex_write_reg} = 15'b0;
      {id_uses_rt, ex_re, ex_regwrite, br_taken, jump, mem_req, mem_ready} = 7'b0;
   endtask

   always @(negedge clk) begin : mon
      exp_t e, a;
      n_cyc++;
      if (q.size() > 0) begin
         e = q.pop_front();
         a = {stall_pc, stall_id, stall_ex, flush_id, flush_ex, mem_timeout, state_o, stall_cnt};
         n_total++;
         if (a === e) n_pass++;
         else $display("FAIL outputs cyc=%0d {spc,sid,sex,fid,fex,to,st,cnt} got=%b want=%b", n_cyc, a, e);
      end
   end

   initial begin
      idle();
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // 1: load-use on rs, then clean
      resetn = 1'b1;
      ex_re = 1; ex_regwrite = 1; ex_write_reg = 5'd3; id_rs = 5'd3;
      step();
      idle(); step();
      // 2: $0 never hazards; rt ignored when not used
      ex_re = 1; ex_regwrite = 1; ex_write_reg = 5'd0; id_rs = 5'd0;
      step();
      ex_write_reg = 5'd5; id_rt = 5'd5; id_rs = 5'd1; id_uses_rt = 0;
      step();
      id_uses_rt = 1; step();
      // 3: branch with coincident load-use, three bubble cycles then clean
      idle(); ex_re = 1; ex_regwrite = 1; ex_write_reg = 5'd7; id_rs = 5'd7; br_taken = 1;
      step();
      idle(); repeat (3) step();
      // 4: reset, then 6-cycle memory wait
      resetn = 0; step(); resetn = 1;
      mem_req = 1; repeat (5) step();
      mem_ready = 1; step();
      idle(); step();
      // 5: timeout after 8 wait cycles
      mem_req = 1; repeat (MT) step();
      idle(); step();
      // 6: reset during a memory wait
      mem_req = 1; repeat (3) step();
      resetn = 0; step();
      resetn = 1; idle(); step();
      // redirect, then memory wait preempting the bubbles
      jump = 1; step();
      jump = 0; mem_req = 1; step();
      mem_ready = 1; step();
      idle(); step();
      // random
      for (int i = 0; i < 2000; i++) begin
         resetn       = ($urandom_range(0, 99) != 0);
         id_rs        = 5'($urandom_range(0, 3));
         id_rt        = 5'($urandom_range(0, 3));
         ex_write_reg = 5'($urandom_range(0, 3));
         id_uses_rt   = 1'($urandom_range(0, 1));
         ex_re        = 1'($urandom_range(0, 1));
         ex_regwrite  = 1'($urandom_range(0, 3) != 0);
         br_taken     = ($urandom_range(0, 7) == 0);
         jump         = ($urandom_range(0, 15) == 0);
         mem_req      = ($urandom_range(0, 6) == 0) || (m_wait > 0);
         mem_ready    = ($urandom_range(0, 5) == 0);
         step();
      end
      idle(); step();
      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         $display("FAIL drain pending=%0d want=0", q.size());
         $fatal(1, "scoreboard did not drain");
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
